// File: rtl/spram_arb.sv
// Single-port VRAM behind an N-channel round-robin arbiter with lane write masks,
// a 1- or 2-stage read pipeline and an ACTIVE/STANDBY/SLEEP/WAKE power state machine.
module spram_arb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 14,
  parameter int LANE_W   = 4,
  parameter int NUM_CH   = 2,
  parameter int RD_LAT   = 1,
  parameter int IDLE_CYC = 16,
  parameter int WAKE_CYC = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_CH-1:0]                   req_valid,
  output logic [NUM_CH-1:0]                   req_ready,
  input  logic [NUM_CH-1:0]                   req_we,
  input  logic [NUM_CH*ADDR_W-1:0]            req_addr,
  input  logic [NUM_CH*DATA_W-1:0]            req_wdata,
  input  logic [NUM_CH*(DATA_W/LANE_W)-1:0]   req_mask,
  output logic [NUM_CH-1:0]                   rsp_valid,
  output logic [DATA_W-1:0]                   rsp_rdata,
  input  logic                                sleep_req,
  output logic [1:0]                          pwr_state
);

  localparam int NL = DATA_W / LANE_W;
  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int IW = $clog2(IDLE_CYC + 2);
  localparam int WW = $clog2(WAKE_CYC + 1);

  typedef enum logic [1:0] {
    PS_ACTIVE  = 2'd0,
    PS_STANDBY = 2'd1,
    PS_SLEEP   = 2'd2,
    PS_WAKE    = 2'd3
  } pwr_t;

  pwr_t              r_state;
  pwr_t              w_state_nxt;
  logic [PW-1:0]     r_ptr;
  logic [IW-1:0]     r_idle_cnt;
  logic [WW-1:0]     r_wake_cnt;

  logic              w_gate;
  logic              w_found;
  logic [NUM_CH-1:0] w_gnt;
  logic [PW-1:0]     w_gnt_idx;
  logic [PW-1:0]     w_scan_sel;
  int                w_scan;

  logic [ADDR_W-1:0] w_ch_addr  [NUM_CH];
  logic [DATA_W-1:0] w_ch_wdata [NUM_CH];
  logic [NL-1:0]     w_ch_mask  [NUM_CH];

  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [NL-1:0]     w_mask;
  logic              w_we;
  logic              w_rd_fire;
  logic              w_wr_fire;
  logic              w_pipe_busy;
  logic [NUM_CH-1:0] w_rsp_v;

  logic [NUM_CH-1:0] r_v1;
  logic [DATA_W-1:0] r_d1;
  logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign w_ch_addr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign w_ch_wdata[g] = req_wdata[g*DATA_W +: DATA_W];
    assign w_ch_mask[g]  = req_mask[g*NL +: NL];
  end

  // Handshake: a channel transfers on a cycle where req_valid[i] && req_ready[i];
  // req_ready is a combinational one-hot grant, only ever raised in ACTIVE with
  // sleep_req low and reset low, and the requester holds its payload until then.
  always_comb begin
    w_gate     = (r_state == PS_ACTIVE) && !sleep_req && !reset;
    w_found    = 1'b0;
    w_gnt      = '0;
    w_gnt_idx  = '0;
    w_scan     = 0;
    w_scan_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_scan = int'(r_ptr) + k;
      if (w_scan >= NUM_CH) w_scan = w_scan - NUM_CH;
      w_scan_sel = w_scan[PW-1:0];
      if (w_gate && !w_found && req_valid[w_scan_sel]) begin
        w_found            = 1'b1;
        w_gnt_idx          = w_scan_sel;
        w_gnt[w_scan_sel]  = 1'b1;
      end
    end
  end

  assign req_ready = w_gnt;
  assign w_addr    = w_ch_addr[w_gnt_idx];
  assign w_wdata   = w_ch_wdata[w_gnt_idx];
  assign w_mask    = w_ch_mask[w_gnt_idx];
  assign w_we      = req_we[w_gnt_idx];
  assign w_wr_fire = w_found && w_we;
  assign w_rd_fire = w_found && !w_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (w_gnt_idx == PW'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  // Array has no reset so it maps onto the SPRAM macro; w_found is already reset-gated.
  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      for (int l = 0; l < NL; l++) begin
        if (w_mask[l]) r_mem[w_addr][l*LANE_W +: LANE_W] <= w_wdata[l*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v1 <= '0;
      r_d1 <= '0;
    end else begin
      r_v1 <= w_rd_fire ? w_gnt : '0;
      if (w_rd_fire) r_d1 <= r_mem[w_addr];
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [NUM_CH-1:0] r_v2;
    logic [DATA_W-1:0] r_d2;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_v2 <= '0;
        r_d2 <= '0;
      end else begin
        r_v2 <= r_v1;
        if (|r_v1) r_d2 <= r_d1;
      end
    end

    assign w_pipe_busy = (|r_v1) || (|r_v2);
    assign w_rsp_v     = r_v2;
    assign rsp_rdata   = r_d2;
  end else begin : g_lat1
    assign w_pipe_busy = |r_v1;
    assign w_rsp_v     = r_v1;
    assign rsp_rdata   = r_d1;
  end

  // A response already staged when reset arrives must not be seen by the client.
  assign rsp_valid = reset ? '0 : w_rsp_v;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PS_ACTIVE: begin
        if (sleep_req) begin
          if (!w_pipe_busy) w_state_nxt = PS_SLEEP;
        end else if ((IDLE_CYC != 0) && !(|req_valid) && !w_pipe_busy &&
                     (r_idle_cnt >= IW'(IDLE_CYC - 1))) begin
          w_state_nxt = PS_STANDBY;
        end
      end
      PS_STANDBY: begin
        if (sleep_req)         w_state_nxt = PS_SLEEP;
        else if (|req_valid)   w_state_nxt = PS_WAKE;
      end
      PS_SLEEP: begin
        if (!sleep_req) w_state_nxt = PS_WAKE;
      end
      PS_WAKE: begin
        if (sleep_req)                              w_state_nxt = PS_SLEEP;
        else if (r_wake_cnt == WW'(WAKE_CYC - 1))   w_state_nxt = PS_ACTIVE;
      end
      default: w_state_nxt = PS_ACTIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= PS_ACTIVE;
    else       r_state <= w_state_nxt;
  end

  // Idle counter saturates so a busy pipeline can hold off standby indefinitely.
  always_ff @(posedge clk) begin
    if (reset || (r_state != PS_ACTIVE) || (|req_valid)) begin
      r_idle_cnt <= '0;
    end else if (r_idle_cnt != IW'(IDLE_CYC)) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (r_state != PS_WAKE)) r_wake_cnt <= '0;
    else                               r_wake_cnt <= r_wake_cnt + 1'b1;
  end

  assign pwr_state = r_state;

endmodule

// File: tb/tb_spram_arb.sv
// Directed bench for spram_arb: one RD_LAT=1 and one RD_LAT=2 instance share stimulus
// and are each compared against hand-computed responses and power states.
module tb_spram_arb;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [27:0] req_addr;
  logic [31:0] req_wdata;
  logic [7:0]  req_mask;
  logic        sleep_req;

  logic [1:0]  l1_ready, l2_ready;
  logic [1:0]  l1_rsp_valid, l2_rsp_valid;
  logic [15:0] l1_rdata, l2_rdata;
  logic [1:0]  l1_pwr, l2_pwr;

  int n_checks = 0;
  int n_fail   = 0;

  logic [17:0] exp_l1_q[$];
  logic [17:0] exp_l2_q[$];
  logic [17:0] exp_e;
  logic [17:0] push_e;

  spram_arb #(.DATA_W(16), .ADDR_W(14), .LANE_W(4), .NUM_CH(2), .RD_LAT(1),
              .IDLE_CYC(16), .WAKE_CYC(3)) u_dut_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(l1_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .rsp_valid(l1_rsp_valid), .rsp_rdata(l1_rdata), .sleep_req(sleep_req),
    .pwr_state(l1_pwr)
  );

  spram_arb #(.DATA_W(16), .ADDR_W(14), .LANE_W(4), .NUM_CH(2), .RD_LAT(2),
              .IDLE_CYC(16), .WAKE_CYC(3)) u_dut_l2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(l2_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .rsp_valid(l2_rsp_valid), .rsp_rdata(l2_rdata), .sleep_req(sleep_req),
    .pwr_state(l2_pwr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic set_ch(input int ch, input logic v, input logic we, input logic [13:0] addr,
                        input logic [15:0] data, input logic [3:0] mask);
    req_valid[ch]            = v;
    req_we[ch]               = we;
    req_addr[ch*14 +: 14]    = addr;
    req_wdata[ch*16 +: 16]   = data;
    req_mask[ch*4 +: 4]      = mask;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_mask  = '0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_both_pwr(input string tag, input logic [1:0] exp);
    check({tag, "_l1"}, {30'd0, l1_pwr}, {30'd0, exp});
    check({tag, "_l2"}, {30'd0, l2_pwr}, {30'd0, exp});
  endtask

  task automatic check_both_ready(input string tag, input logic [1:0] exp);
    check({tag, "_l1"}, {30'd0, l1_ready}, {30'd0, exp});
    check({tag, "_l2"}, {30'd0, l2_ready}, {30'd0, exp});
  endtask

  initial begin
    reset     = 1'b1;
    sleep_req = 1'b0;
    clear_reqs();
    repeat (3) @(posedge clk);

    // reset state, with a write offered while reset is held
    @(negedge clk);
    set_ch(0, 1'b1, 1'b1, 14'h0005, 16'hAAAA, 4'hF);
    #1;
    check_both_ready("rst_ready", 2'b00);
    check("rst_rspv_l1", l1_rsp_valid, 2'b00);
    check("rst_rspv_l2", l2_rsp_valid, 2'b00);
    check("rst_rdata_l1", l1_rdata, 16'h0000);
    check("rst_rdata_l2", l2_rdata, 16'h0000);
    check_both_pwr("rst_pwr", 2'd0);
    @(negedge clk);
    reset = 1'b0;
    clear_reqs();

    // basic write then read-back on ch0
    @(negedge clk);
    set_ch(0, 1'b1, 1'b1, 14'h0123, 16'hBEEF, 4'b1111);
    #1 check_both_ready("wr0_ready", 2'b01);
    @(negedge clk);
    set_ch(0, 1'b1, 1'b0, 14'h0123, 16'h0000, 4'b0000);
    #1 check_both_ready("rd0_ready", 2'b01);
    @(negedge clk);
    clear_reqs();
    #1;
    check("rd0_rspv_l1", l1_rsp_valid, 2'b01);
    check("rd0_data_l1", l1_rdata, 16'hBEEF);
    check("rd0_rspv_l2_early", l2_rsp_valid, 2'b00);
    @(negedge clk);
    #1;
    check("rd0_rspv_l2", l2_rsp_valid, 2'b01);
    check("rd0_data_l2", l2_rdata, 16'hBEEF);
    check("rd0_rspv_l1_done", l1_rsp_valid, 2'b00);

    // masked write on ch1: lanes 0 and 2 replaced
    @(negedge clk);
    set_ch(1, 1'b1, 1'b1, 14'h0123, 16'h1234, 4'b0101);
    #1 check_both_ready("mwr_ready", 2'b10);
    @(negedge clk);
    set_ch(1, 1'b1, 1'b0, 14'h0123, 16'h0000, 4'b0000);
    #1 check_both_ready("mrd_ready", 2'b10);
    @(negedge clk);
    clear_reqs();
    #1;
    check("mrd_rspv_l1", l1_rsp_valid, 2'b10);
    check("mrd_data_l1", l1_rdata, 16'hB2E4);
    @(negedge clk);
    #1;
    check("mrd_rspv_l2", l2_rsp_valid, 2'b10);
    check("mrd_data_l2", l2_rdata, 16'hB2E4);

    // preload two distinct words for the round-robin run
    @(negedge clk);
    set_ch(0, 1'b1, 1'b1, 14'h0200, 16'h5A5A, 4'hF);
    #1 check_both_ready("pre0_ready", 2'b01);
    @(negedge clk);
    clear_reqs();
    set_ch(1, 1'b1, 1'b1, 14'h0201, 16'hC3C3, 4'hF);
    #1 check_both_ready("pre1_ready", 2'b10);

    // round robin: both channels hold reads for 4 cycles from pointer 0
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i < 4) begin
        set_ch(0, 1'b1, 1'b0, 14'h0200, 16'h0000, 4'h0);
        set_ch(1, 1'b1, 1'b0, 14'h0201, 16'h0000, 4'h0);
      end else begin
        clear_reqs();
      end
      #1;
      if (i < 4) begin
        push_e = (i % 2 == 0) ? {2'b01, 16'h5A5A} : {2'b10, 16'hC3C3};
        check_both_ready("rr_ready", push_e[17:16]);
        exp_l1_q.push_back(push_e);
        exp_l2_q.push_back(push_e);
      end
      if (i >= 1 && i <= 4) begin
        exp_e = exp_l1_q.pop_front();
        check("rr_rspv_l1", l1_rsp_valid, exp_e[17:16]);
        check("rr_data_l1", l1_rdata, exp_e[15:0]);
      end
      if (i >= 2) begin
        exp_e = exp_l2_q.pop_front();
        check("rr_rspv_l2", l2_rsp_valid, exp_e[17:16]);
        check("rr_data_l2", l2_rdata, exp_e[15:0]);
      end
    end

    // auto-standby: the last two loop cycles were idle cycles 1 and 2
    for (int k = 3; k <= 17; k++) begin
      @(negedge clk);
      #1;
      if (k == 16) check_both_pwr("idle16_pwr", 2'd0);
      if (k == 17) check_both_pwr("stby_pwr", 2'd1);
    end

    // wake on a ch0 read
    @(negedge clk);
    set_ch(0, 1'b1, 1'b0, 14'h0200, 16'h0000, 4'h0);
    #1;
    check_both_ready("stby_ready", 2'b00);
    check_both_pwr("stby_req_pwr", 2'd1);
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      #1;
      check_both_pwr("wake_pwr", 2'd3);
      check_both_ready("wake_ready", 2'b00);
    end
    @(negedge clk);
    #1;
    check_both_pwr("act_pwr", 2'd0);
    check_both_ready("act_ready", 2'b01);
    @(negedge clk);
    clear_reqs();
    #1;
    check("wk_rspv_l1", l1_rsp_valid, 2'b01);
    check("wk_data_l1", l1_rdata, 16'h5A5A);
    @(negedge clk);
    #1;
    check("wk_rspv_l2", l2_rsp_valid, 2'b01);
    check("wk_data_l2", l2_rdata, 16'h5A5A);

    // sleep with a read in flight; ch0 stays pending throughout
    @(negedge clk);
    set_ch(1, 1'b1, 1'b0, 14'h0201, 16'h0000, 4'h0);
    #1 check_both_ready("slp_rd_ready", 2'b10);
    @(negedge clk);
    clear_reqs();
    set_ch(0, 1'b1, 1'b0, 14'h0123, 16'h0000, 4'h0);
    sleep_req = 1'b1;
    #1;
    check_both_ready("slp_gate_ready", 2'b00);
    check("slp_rspv_l1", l1_rsp_valid, 2'b10);
    check("slp_data_l1", l1_rdata, 16'hC3C3);
    check_both_pwr("slp_drain_pwr", 2'd0);
    @(negedge clk);
    #1;
    check_both_ready("slp_gate2_ready", 2'b00);
    check("slp_rspv_l2", l2_rsp_valid, 2'b10);
    check("slp_data_l2", l2_rdata, 16'hC3C3);
    check("slp_rspv_l1_done", l1_rsp_valid, 2'b00);
    check("slp_pwr_l1_drain", l1_pwr, 2'd0);
    @(negedge clk);
    #1;
    check("slp_pwr_l1", l1_pwr, 2'd2);
    check("slp_pwr_l2_drain", l2_pwr, 2'd0);
    check("slp_rspv_l2_done", l2_rsp_valid, 2'b00);
    @(negedge clk);
    #1;
    check_both_pwr("slp_pwr", 2'd2);
    check_both_ready("slp_ready", 2'b00);

    // release sleep, re-request it mid-wake, then release again
    @(negedge clk);
    sleep_req = 1'b0;
    #1 check_both_pwr("slp_hold_pwr", 2'd2);
    @(negedge clk);
    #1 check_both_pwr("wk1_pwr", 2'd3);
    @(negedge clk);
    sleep_req = 1'b1;
    #1 check_both_pwr("wk2_pwr", 2'd3);
    @(negedge clk);
    sleep_req = 1'b0;
    #1 check_both_pwr("reslp_pwr", 2'd2);
    for (int w = 0; w < 3; w++) begin
      @(negedge clk);
      #1;
      check_both_pwr("wk3_pwr", 2'd3);
      check_both_ready("wk3_ready", 2'b00);
    end
    @(negedge clk);
    #1;
    check_both_pwr("post_slp_pwr", 2'd0);
    check_both_ready("post_slp_ready", 2'b01);
    @(negedge clk);
    clear_reqs();
    #1;
    check("ret_rspv_l1", l1_rsp_valid, 2'b01);
    check("ret_data_l1", l1_rdata, 16'hB2E4);
    @(negedge clk);
    #1;
    check("ret_rspv_l2", l2_rsp_valid, 2'b01);
    check("ret_data_l2", l2_rdata, 16'hB2E4);

    // reset on the cycle after a read grant, with a write offered during reset
    @(negedge clk);
    set_ch(0, 1'b1, 1'b0, 14'h0200, 16'h0000, 4'h0);
    #1 check_both_ready("mr_rd_ready", 2'b01);
    @(negedge clk);
    clear_reqs();
    set_ch(1, 1'b1, 1'b1, 14'h0200, 16'hFFFF, 4'hF);
    reset = 1'b1;
    #1;
    check("mr_rspv_l1", l1_rsp_valid, 2'b00);
    check("mr_rspv_l2", l2_rsp_valid, 2'b00);
    check_both_ready("mr_ready", 2'b00);
    @(negedge clk);
    reset = 1'b0;
    clear_reqs();
    #1;
    check("mr_post_rspv_l1", l1_rsp_valid, 2'b00);
    check("mr_post_rspv_l2", l2_rsp_valid, 2'b00);
    check("mr_post_data_l1", l1_rdata, 16'h0000);
    check("mr_post_data_l2", l2_rdata, 16'h0000);
    check_both_pwr("mr_post_pwr", 2'd0);
    @(negedge clk);
    #1 check("mr_late_rspv_l2", l2_rsp_valid, 2'b00);
    @(negedge clk);
    set_ch(0, 1'b1, 1'b0, 14'h0200, 16'h0000, 4'h0);
    #1 check_both_ready("mr_rd2_ready", 2'b01);
    @(negedge clk);
    clear_reqs();
    #1;
    check("mr_rd2_rspv_l1", l1_rsp_valid, 2'b01);
    check("mr_rd2_data_l1", l1_rdata, 16'h5A5A);
    @(negedge clk);
    #1;
    check("mr_rd2_rspv_l2", l2_rsp_valid, 2'b01);
    check("mr_rd2_data_l2", l2_rdata, 16'h5A5A);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
